// File: rtl/scale_sequencer.sv
// Display scale sequencer: frame-aligned scale mode changes plus a 2-stage pixel-to-address pipeline.
// Optional automatic mode stepping every AUTO_FRAMES frames is enabled with `define SCALE_AUTOCYCLE_EN.
module scale_sequencer #(
   parameter int FB_WIDTH    = 240,
   parameter int FB_HEIGHT   = 320,
   parameter int AUTO_FRAMES = 60
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        new_frame_in,
   input  logic        cycle_in,
   input  logic        load_in,
   input  logic [1:0]  load_scale_in,
   output logic [1:0]  scale_out,
   output logic        pending_out,
   output logic        reject_out,
   output logic [16:0] addr_out,
   output logic        addr_valid_out,
   output logic [10:0] hcount_out,
   output logic [9:0]  vcount_out
);

   localparam logic [0:0] ST_STABLE  = 1'b0;
   localparam logic [0:0] ST_PENDING = 1'b1;

   localparam logic [1:0] M_1X   = 2'b00;
   localparam logic [1:0] M_RSVD = 2'b01;
   localparam logic [1:0] M_4X2  = 2'b10;
   localparam logic [1:0] M_2X   = 2'b11;

   localparam logic [31:0] W1 = 32'(FB_WIDTH);
   localparam logic [31:0] W2 = 32'(2 * FB_WIDTH);
   localparam logic [31:0] W4 = 32'(4 * FB_WIDTH);
   localparam logic [31:0] H1 = 32'(FB_HEIGHT);
   localparam logic [31:0] H2 = 32'(2 * FB_HEIGHT);
   localparam logic [16:0] FB_W17 = 17'(FB_WIDTH);

   function automatic logic [1:0] next_mode(input logic [1:0] m);
      case (m)
         M_1X:    return M_2X;
         M_2X:    return M_4X2;
         default: return M_1X;
      endcase
   endfunction

   // Mode FSM; pending_out is the visible state (PENDING = 1).
   logic [0:0] state_q, state_d;
   logic [1:0] scale_q, scale_d;
   logic [1:0] target_q, target_d;
   logic       reject_q, reject_d;

   logic [1:0] base_mode;
   logic       load_ok;
   logic       ext_cycle;
   logic       auto_req;

   assign base_mode = (state_q == ST_PENDING) ? target_q : scale_q;
   assign load_ok   = load_in && (load_scale_in != M_RSVD) &&
                      !((state_q == ST_STABLE) && (load_scale_in == scale_q));
   assign ext_cycle = cycle_in && !load_in;

   always_comb begin
      state_d  = state_q;
      scale_d  = scale_q;
      target_d = target_q;
      reject_d = load_in && (load_scale_in == M_RSVD);
      if (new_frame_in && (state_q == ST_PENDING)) begin
         scale_d = target_q;
         state_d = ST_STABLE;
      end
      if (load_ok) begin
         state_d  = ST_PENDING;
         target_d = load_scale_in;
      end else if (ext_cycle || auto_req) begin
         state_d  = ST_PENDING;
         target_d = next_mode(base_mode);
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q  <= ST_STABLE;
         scale_q  <= M_1X;
         target_q <= M_1X;
         reject_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         scale_q  <= scale_d;
         target_q <= target_d;
         reject_q <= reject_d;
      end
   end

`ifdef SCALE_AUTOCYCLE_EN
   localparam int CW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
   localparam logic [CW-1:0] LAST = CW'(AUTO_FRAMES - 1);

   logic [CW-1:0] frame_cnt_q, frame_cnt_d, frame_cnt_inc;
   logic          auto_q, auto_d;
   logic          ext_req;

   assign ext_req       = load_ok || ext_cycle;
   assign frame_cnt_inc = frame_cnt_q + 1'b1;
   assign auto_req      = auto_q && !ext_req;

   // The internal request becomes pending one cycle after the triggering frame start.
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      auto_d      = 1'b0;
      if (ext_req) begin
         frame_cnt_d = '0;
      end else if (new_frame_in) begin
         if (frame_cnt_q == LAST) begin
            frame_cnt_d = '0;
         end else begin
            frame_cnt_d = frame_cnt_inc;
            auto_d      = (frame_cnt_inc == LAST);
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         frame_cnt_q <= '0;
         auto_q      <= 1'b0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         auto_q      <= auto_d;
      end
   end
`else
   // No automatic stepping; the comparison is constant-false for any legal AUTO_FRAMES.
   assign auto_req = (AUTO_FRAMES < 0);
`endif

   logic [31:0] h32, v32;
   logic [10:0] sh_d, s1_sh_q;
   logic [9:0]  sv_d, s1_sv_q;
   logic        valid_d, s1_valid_q;
   logic [10:0] s1_h_q;
   logic [9:0]  s1_v_q;

   assign h32 = 32'(hcount_in);
   assign v32 = 32'(vcount_in);

   always_comb begin
      case (scale_q)
         M_2X: begin
            sh_d    = hcount_in >> 1;
            sv_d    = vcount_in >> 1;
            valid_d = (h32 < W2) && (v32 < H2);
         end
         M_4X2: begin
            sh_d    = hcount_in >> 2;
            sv_d    = vcount_in >> 1;
            valid_d = (h32 < W4) && (v32 < H2);
         end
         default: begin
            sh_d    = hcount_in;
            sv_d    = vcount_in;
            valid_d = (h32 < W1) && (v32 < H1);
         end
      endcase
   end

   logic [16:0] addr_full, addr_d;
   logic [16:0] addr_q;
   logic        addr_valid_q;
   logic [10:0] h2_q;
   logic [9:0]  v2_q;

   assign addr_full = ({7'd0, s1_sv_q} * FB_W17) + {6'd0, s1_sh_q};
   assign addr_d    = s1_valid_q ? addr_full : 17'd0;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         s1_sh_q      <= '0;
         s1_sv_q      <= '0;
         s1_valid_q   <= 1'b0;
         s1_h_q       <= '0;
         s1_v_q       <= '0;
         addr_q       <= '0;
         addr_valid_q <= 1'b0;
         h2_q         <= '0;
         v2_q         <= '0;
      end else begin
         s1_sh_q      <= sh_d;
         s1_sv_q      <= sv_d;
         s1_valid_q   <= valid_d;
         s1_h_q       <= hcount_in;
         s1_v_q       <= vcount_in;
         addr_q       <= addr_d;
         addr_valid_q <= s1_valid_q;
         h2_q         <= s1_h_q;
         v2_q         <= s1_v_q;
      end
   end

   assign scale_out      = scale_q;
   assign pending_out    = state_q;
   assign reject_out     = reject_q;
   assign addr_out       = addr_q;
   assign addr_valid_out = addr_valid_q;
   assign hcount_out     = h2_q;
   assign vcount_out     = v2_q;

endmodule

// File: tb/tb_scale_sequencer.sv
// Self-checking bench for scale_sequencer: table of request/pixel vectors, pixel scoreboard, reset and autocycle sequences.
module tb_scale_sequencer;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic        new_frame_in, cycle_in, load_in;
   logic [1:0]  load_scale_in;
   logic [1:0]  scale_out;
   logic        pending_out, reject_out;
   logic [16:0] addr_out;
   logic        addr_valid_out;
   logic [10:0] hcount_out;
   logic [9:0]  vcount_out;

   always #5 clk_in = ~clk_in;

   scale_sequencer #(.FB_WIDTH(240), .FB_HEIGHT(320), .AUTO_FRAMES(3)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
      .new_frame_in(new_frame_in), .cycle_in(cycle_in), .load_in(load_in),
      .load_scale_in(load_scale_in), .scale_out(scale_out), .pending_out(pending_out),
      .reject_out(reject_out), .addr_out(addr_out), .addr_valid_out(addr_valid_out),
      .hcount_out(hcount_out), .vcount_out(vcount_out)
   );

   typedef struct {
      logic [10:0] h;
      logic [9:0]  v;
      logic        nf, cyc, ld;
      logic [1:0]  lds;
      logic [1:0]  e_scale;
      logic        e_pend, e_rej;
   } vec_t;

   int          checks = 0;
   int          failures = 0;
   logic [38:0] exp_q[$];
   logic [1:0]  cur_scale;
   vec_t        vecs[32];

   function automatic vec_t mk(int h, int v, bit nf, bit cyc, bit ld, int lds, int es, bit ep, bit er);
      vec_t r;
      r.h = 11'(h); r.v = 10'(v); r.nf = nf; r.cyc = cyc; r.ld = ld;
      r.lds = 2'(lds); r.e_scale = 2'(es); r.e_pend = ep; r.e_rej = er;
      return r;
   endfunction

   // Expected {valid, addr, h, v} for a pixel sampled under the given mode.
   function automatic logic [38:0] ref_pixel(input logic [1:0] mode, input logic [10:0] h, input logic [9:0] v);
      int sx, sy, hi, vi;
      logic ok;
      logic [16:0] a;
      hi = int'(h);
      vi = int'(v);
      case (mode)
         2'b11:   begin sx = 2; sy = 2; end
         2'b10:   begin sx = 4; sy = 2; end
         default: begin sx = 1; sy = 1; end
      endcase
      ok = (hi < sx * 240) && (vi < sy * 320);
      a  = ok ? 17'((vi / sy) * 240 + hi / sx) : 17'd0;
      return {ok, a, h, v};
   endfunction

   task automatic check1(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic step_px(input logic [10:0] h, input logic [9:0] v, input logic nf,
                          input logic cyc, input logic ld, input logic [1:0] lds);
      logic [38:0] got, exp;
      hcount_in = h; vcount_in = v;
      new_frame_in = nf; cycle_in = cyc; load_in = ld; load_scale_in = lds;
      exp_q.push_back(ref_pixel(cur_scale, h, v));
      tick();
      new_frame_in = 1'b0; cycle_in = 1'b0; load_in = 1'b0;
      if (exp_q.size() == 2) begin
         exp = exp_q.pop_front();
         got = {addr_valid_out, addr_out, hcount_out, vcount_out};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL pixel valid/addr/h/v actual=%0d/%0d/%0d/%0d required=%0d/%0d/%0d/%0d",
                     got[38], got[37:21], got[20:10], got[9:0], exp[38], exp[37:21], exp[20:10], exp[9:0]);
         end
      end
   endtask

   task automatic run_vec(input vec_t r, input int idx);
      step_px(r.h, r.v, r.nf, r.cyc, r.ld, r.lds);
      check1($sformatf("scale row %0d", idx), int'(scale_out), int'(r.e_scale));
      check1($sformatf("pending row %0d", idx), int'(pending_out), int'(r.e_pend));
      check1($sformatf("reject row %0d", idx), int'(reject_out), int'(r.e_rej));
      cur_scale = r.e_scale;
   endtask

   initial begin
      rst_in = 1'b1; hcount_in = '0; vcount_in = '0;
      new_frame_in = 1'b0; cycle_in = 1'b0; load_in = 1'b0; load_scale_in = 2'b00;
      cur_scale = 2'b00;
      hcount_in = 11'd10; vcount_in = 10'd5;
      repeat (3) tick();
      check1("reset scale", int'(scale_out), 0);
      check1("reset pending", int'(pending_out), 0);
      check1("reset reject", int'(reject_out), 0);
      check1("reset addr", int'(addr_out), 0);
      check1("reset valid", int'(addr_valid_out), 0);
      check1("reset hcount", int'(hcount_out), 0);
      check1("reset vcount", int'(vcount_out), 0);
      rst_in = 1'b0;

`ifndef SCALE_AUTOCYCLE_EN
      //            h     v    nf cyc ld lds scale pend rej
      vecs[0]  = mk(10,   5,   0, 0, 0, 0, 0, 0, 0);
      vecs[1]  = mk(20,   0,   0, 0, 0, 0, 0, 0, 0);
      vecs[2]  = mk(100,  40,  0, 1, 0, 0, 0, 1, 0);
      vecs[3]  = mk(0,    0,   0, 0, 0, 0, 0, 1, 0);
      vecs[4]  = mk(239,  319, 1, 0, 0, 0, 3, 0, 0);
      vecs[5]  = mk(100,  40,  0, 0, 0, 0, 3, 0, 0);
      vecs[6]  = mk(479,  639, 0, 0, 1, 1, 3, 0, 1);
      vecs[7]  = mk(480,  10,  0, 0, 0, 0, 3, 0, 0);
      vecs[8]  = mk(30,   640, 0, 0, 1, 3, 3, 0, 0);
      vecs[9]  = mk(7,    9,   0, 0, 1, 0, 3, 1, 0);
      vecs[10] = mk(8,    9,   0, 0, 1, 1, 3, 1, 1);
      vecs[11] = mk(9,    9,   1, 0, 0, 0, 0, 0, 0);
      vecs[12] = mk(240,  319, 0, 1, 1, 2, 0, 1, 0);
      vecs[13] = mk(123,  45,  1, 0, 0, 0, 2, 0, 0);
      vecs[14] = mk(963,  100, 0, 0, 0, 0, 2, 0, 0);
      vecs[15] = mk(959,  639, 0, 0, 0, 0, 2, 0, 0);
      vecs[16] = mk(500,  300, 0, 0, 0, 0, 2, 0, 0);
      vecs[17] = mk(960,  0,   0, 1, 0, 0, 2, 1, 0);
      vecs[18] = mk(0,    640, 1, 0, 0, 0, 0, 0, 0);
      vecs[19] = mk(1,    1,   0, 1, 0, 0, 0, 1, 0);
      vecs[20] = mk(2,    2,   0, 1, 0, 0, 0, 1, 0);
      vecs[21] = mk(3,    3,   1, 0, 0, 0, 2, 0, 0);
      vecs[22] = mk(1,    1,   0, 0, 0, 0, 2, 0, 0);
      vecs[23] = mk(4,    4,   1, 1, 0, 0, 2, 1, 0);
      vecs[24] = mk(300,  200, 0, 0, 0, 0, 2, 1, 0);
      vecs[25] = mk(5,    5,   1, 0, 0, 0, 0, 0, 0);
      vecs[26] = mk(239,  319, 0, 0, 0, 0, 0, 0, 0);
      vecs[27] = mk(240,  0,   0, 0, 0, 0, 0, 0, 0);
      vecs[28] = mk(6,    6,   0, 1, 0, 0, 0, 1, 0);
      vecs[29] = mk(7,    7,   1, 1, 0, 0, 3, 1, 0);
      vecs[30] = mk(8,    8,   1, 0, 0, 0, 2, 0, 0);
      vecs[31] = mk(2047, 1023,0, 0, 0, 0, 2, 0, 0);
      for (int i = 0; i < 32; i++) run_vec(vecs[i], i);

      for (int i = 0; i < 40; i++)
         run_vec(mk($urandom_range(0, 1100), $urandom_range(0, 700), 0, 0, 0, 0, 2, 0, 0), 100 + i);

      // Reset while a request is pending and a valid pixel is in flight.
      run_vec(mk(10, 5, 0, 1, 0, 0, 2, 1, 0), 200);
      rst_in = 1'b1; hcount_in = 11'd10; vcount_in = 10'd5;
      tick();
      check1("midreset valid", int'(addr_valid_out), 0);
      check1("midreset addr", int'(addr_out), 0);
      check1("midreset hcount", int'(hcount_out), 0);
      check1("midreset scale", int'(scale_out), 0);
      check1("midreset pending", int'(pending_out), 0);
      exp_q.delete();
      cur_scale = 2'b00;
      rst_in = 1'b0;
      step_px(11'd10, 10'd5, 1'b0, 1'b0, 1'b0, 2'b00);
      check1("postreset first valid", int'(addr_valid_out), 0);
      run_vec(mk(20, 3, 1, 0, 0, 0, 0, 0, 0), 201);
      run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 202);
`else
      begin
         logic [1:0] seq[3];
         int k;
         seq[0] = 2'b00; seq[1] = 2'b11; seq[2] = 2'b10;
         for (k = 1; k <= 10; k++) begin
            new_frame_in = 1'b1;
            tick();
            new_frame_in = 1'b0;
            repeat (3) tick();
            check1($sformatf("auto scale frame %0d", k), int'(scale_out), int'(seq[(k / 3) % 3]));
         end
         rst_in = 1'b1;
         tick();
         check1("auto reset scale", int'(scale_out), 0);
         rst_in = 1'b0;
         for (k = 1; k <= 3; k++) begin
            new_frame_in = 1'b1;
            tick();
            new_frame_in = 1'b0;
            repeat (3) tick();
            check1($sformatf("auto restart frame %0d", k), int'(scale_out), int'(seq[k / 3]));
         end
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
